// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock flag into staged synchronous resets.
// Resets release in order once lock is trusted; a lock loss re-asserts them all and is counted.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int STAGE_GAP_CYCLES   = 8,
  parameter int NUM_STAGES         = 3,
  parameter int COUNT_WIDTH        = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   locked,
  input  logic                   clear_count,
  output logic [NUM_STAGES-1:0]  reset_out,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [COUNT_WIDTH-1:0] lock_lost_count
);

  localparam int MAX_AB =
    (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
    LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int MAX_C =
    (MAX_AB > STAGE_GAP_CYCLES) ? MAX_AB : STAGE_GAP_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABILISE,
    HOLD,
    RELEASE,
    RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]  rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic                   lost_q, lost_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [NUM_STAGES-1:0]  shifted;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], locked};
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    lost_d  = 1'b0;
    count_d = count_q;
    // Stages release LSB first by shifting zeros in from the bottom.
    shifted = rst_q << 1;

    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = STABILISE;
      end
      STABILISE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CW'(RESET_HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          rst_d   = shifted;
          state_d = RELEASE;
          if (shifted == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == CW'(STAGE_GAP_CYCLES - 1)) begin
          cnt_d = '0;
          rst_d = shifted;
          if (shifted == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Losing trusted lock overrides whatever the sequence was doing.
    if (!lock_s && (state_q == HOLD || state_q == RELEASE ||
                    state_q == RUN)) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      lost_d  = 1'b1;
    end

    if (clear_count)
      count_d = lost_d ? COUNT_WIDTH'(1) : '0;
    else if (lost_d && !(&count_q))
      count_d = count_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      sync_q  <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
      count_q <= count_d;
    end
  end

  assign reset_out       = rst_q;
  assign ready           = ready_q;
  assign lock_lost       = lost_q;
  assign lock_lost_count = count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock traffic,
// every cycle compared against an elapsed-time model of the release schedule.
module tb_pll_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int HOLDC  = 4;
  localparam int GAP    = 2;
  localparam int NST    = 3;
  localparam int CWID   = 4;
  localparam int CMAX   = (1 << CWID) - 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            locked;
  logic            clear_count;
  logic [NST-1:0]  reset_out;
  logic            ready;
  logic            lock_lost;
  logic [CWID-1:0] lock_lost_count;

  pll_reset_sequencer #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(STABLE),
    .RESET_HOLD_CYCLES (HOLDC),
    .STAGE_GAP_CYCLES  (GAP),
    .NUM_STAGES        (NST),
    .COUNT_WIDTH       (CWID)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .locked         (locked),
    .clear_count    (clear_count),
    .reset_out      (reset_out),
    .ready          (ready),
    .lock_lost      (lock_lost),
    .lock_lost_count(lock_lost_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: lock is a delayed copy of locked; outputs depend only on
  // how many edges have passed since lock_s was first seen high.
  bit hist [SYNC];
  bit m_active;
  int m_t;
  int m_n = 0;
  int m_count;
  bit m_lost;

  function automatic void model_reset();
    for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
    m_active = 1'b0;
    m_count  = 0;
    m_lost   = 1'b0;
  endfunction

  function automatic logic [NST-1:0] exp_rst();
    logic [NST-1:0] r;
    for (int k = 0; k < NST; k++)
      r[k] = !(m_active &&
               (m_n - m_t) >= STABLE + HOLDC + k * GAP);
    return r;
  endfunction

  function automatic logic exp_ready();
    return m_active &&
           (m_n - m_t) >= STABLE + HOLDC + (NST - 1) * GAP;
  endfunction

  function automatic void model_edge();
    bit ls;
    m_n++;
    if (reset) begin
      model_reset();
      return;
    end
    ls = hist[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = locked;
    m_lost = 1'b0;
    if (!ls) begin
      if (m_active && (m_n - m_t) >= STABLE + 1) m_lost = 1'b1;
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t      = m_n;
    end
    if (clear_count) m_count = m_lost ? 1 : 0;
    else if (m_lost && m_count < CMAX) m_count++;
  endfunction

  task automatic check_all();
    chk("reset_out", 32'(reset_out), 32'(exp_rst()));
    chk("ready", 32'(ready), 32'(exp_ready()));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("count", 32'(lock_lost_count), 32'(m_count));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_all();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    locked      = 1'b0;
    clear_count = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b0;

    // idle without lock
    cyc(100);

    // clean lock-up: T lands on the third edge
    locked = 1'b1;
    cyc(22);
    chk("t2_hold", 32'(reset_out), 32'h7);
    cyc(1);
    chk("t2_r0", 32'(reset_out), 32'h6);
    cyc(2);
    chk("t2_r1", 32'(reset_out), 32'h4);
    cyc(2);
    chk("t2_r2", 32'(reset_out), 32'h0);
    chk("t2_ready", 32'(ready), 32'h1);
    cyc(200);

    // glitch while stabilising
    apply_reset();
    locked = 1'b1;
    cyc(SYNC + 11);
    locked = 1'b0;
    cyc(3);
    locked = 1'b1;
    cyc(60);
    chk("t3_count", 32'(lock_lost_count), 32'h0);

    // single-cycle drop in RUN
    locked = 1'b0;
    cyc(1);
    locked = 1'b1;
    cyc(60);
    chk("t4_count", 32'(lock_lost_count), 32'h1);

    // saturate the counter
    repeat (16) begin
      locked = 1'b0;
      cyc(1);
      locked = 1'b1;
      cyc(25);
    end
    chk("t5_sat", 32'(lock_lost_count), 32'hf);
    locked = 1'b0;
    cyc(1);
    locked = 1'b1;
    cyc(1);
    clear_count = 1'b1;
    cyc(1);
    clear_count = 1'b0;
    chk("t5_clr_loss", 32'(lock_lost_count), 32'h1);
    clear_count = 1'b1;
    cyc(1);
    clear_count = 1'b0;
    chk("t5_clr", 32'(lock_lost_count), 32'h0);

    // reset in the middle of RELEASE
    apply_reset();
    cyc(23);
    chk("t6_r0", 32'(reset_out), 32'h6);
    cyc(1);
    apply_reset();
    chk("t6_count", 32'(lock_lost_count), 32'h0);
    cyc(22);
    chk("t6_hold", 32'(reset_out), 32'h7);
    cyc(5);
    chk("t6_ready", 32'(ready), 32'h1);

    // random lock traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) locked = ~locked;
      clear_count = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 599) == 0) apply_reset();
      else cyc(1);
    end
    clear_count = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
